mandel_line_dispatcher: RTL and testbench
=========================================

Name: mandel_line_dispatcher

Overview:
Per-line work scheduler for the multi-engine Mandelbrot datapath. On a line-start request it hands pixel indices 0..X_SIZE-1 to a pool of NUM_ENGINES iteration engines. It collects their escape depths through a round-robin arbiter and writes each result into the line results buffer at the pixel's own index. It signals line completion to the LUT/stream front end, which then re-issues line_start for the next row.

Parameters:
NUM_ENGINES, 4, number of iteration engines in the pool (1..16)
X_SIZE, 640, pixels per line
DEPTH_W, 10, escape-depth width
ADDR_W, $clog2(X_SIZE), derived localparam; pixel index width (10 at default)

Ports:
out_stream_aclk  in  1  single clock for all logic
periph_resetn  in  1  reset; asynchronous, active-low
line_start  in  1  request to compute one line; accepted only in IDLE
line_busy  out  1  high in DISPATCH, DRAIN and DONE
line_done  out  1  one-cycle pulse when every pixel of the line is written
eng_idle  in  NUM_ENGINES  engine i can accept a new pixel
eng_start  out  NUM_ENGINES  one-hot launch pulse
eng_x  out  ADDR_W  pixel index for the launched engine; valid with eng_start
eng_done  in  NUM_ENGINES  engine i result valid; held until acked
eng_depth  in  NUM_ENGINES*DEPTH_W  engine i depth in slice [i*DEPTH_W +: DEPTH_W]
eng_ack  out  NUM_ENGINES  one-hot, combinational; result consumed this cycle
wr_en  out  1  results buffer write strobe
wr_addr  out  ADDR_W  results buffer address
wr_data  out  DEPTH_W  depth to store

Behaviour:
- Reset (async assert, sync release): state=IDLE; next_x=0; written=0; inflight=0; rr_ptr=0; tags=0. All outputs 0.
- next_x and written are ADDR_W+1 bits wide so they can hold X_SIZE.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
  - IDLE: line_start=1 -> DISPATCH; clear next_x, written, inflight.
  - DISPATCH: issue launches; when the launch of index X_SIZE-1 occurs -> DRAIN.
  - DRAIN: no launches; when written==X_SIZE -> DONE.
  - DONE: line_done=1 for one cycle -> IDLE.
  - line_start outside IDLE is ignored (no queuing).
- Launch rule, DISPATCH only, at most one per cycle:
  - Select the lowest i with eng_idle[i] & !inflight[i].
  - Drive eng_start[i]=1 and eng_x=next_x. These are registered outputs, high for exactly one cycle.
  - Set tag[i]<=next_x and inflight[i]<=1; next_x<=next_x+1.
  - No eligible engine -> no launch; next_x holds.
- Collect rule, DISPATCH and DRAIN:
  - Request vector = eng_done & inflight.
  - Round-robin grant: search from rr_ptr upward with wrap; g = first requester.
  - eng_ack[g]=1 combinationally in the same cycle.
  - At the clock edge: inflight[g]<=0, rr_ptr<=(g+1) mod NUM_ENGINES, written<=written+1.
  - Registered write the next cycle: wr_en=1, wr_addr=tag[g], wr_data=eng_depth slice g. Latency is 1 cycle from grant to wr_en.
  - No request -> no ack, wr_en=0, rr_ptr holds.
- eng_done from an engine with inflight=0 is ignored: never acked, never written.
- A launch and a collect may occur in the same cycle on different engines. An engine acked in cycle T is eligible for launch from T+1 (inflight is sampled at cycle start).
- Order of writes follows completion order, not pixel order. Each index 0..X_SIZE-1 is written exactly once per line.
- Timing of line_done:
  - Final grant at cycle T; final wr_en at T+1.
  - At T+1 written==X_SIZE in DRAIN -> DONE; line_done=1 at T+2.
  - The buffer is therefore complete when line_done is seen.
- Reset mid-line: immediate return to IDLE with all outputs 0. Partial buffer contents are undefined; engines share the same reset.

Optional Feature:
Macro DISPATCH_PERF_EN.
- Defined: adds output line_cycles [31:0].
  - Internal counter clears on line_start acceptance and increments every cycle while line_busy.
  - line_cycles latches the count on the line_done cycle; reset value 0; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- NUM_ENGINES=4; engine model idle, done 3 cycles after start, depth=x%200; pulse line_start -> 640 wr_en pulses, every addr 0..639 exactly once with wr_data=addr%200; exactly one line_done, one cycle after the last wr_en.
- rr_ptr=0; all 4 engines raise eng_done in the same cycle (tags 8,9,10,11) -> acks to engines 0,1,2,3 on 4 consecutive cycles; wr_addr 8,9,10,11; one wr_en per cycle.
- eng_idle[0] tied 0 -> eng_start[0] never asserts; line still completes with 640 writes.
- Second line_start while line_busy=1 -> ignored; wr_en count stays 640; a single line_done.
- Assert periph_resetn=0 asynchronously after x=100 is launched -> all outputs 0 before the next edge, state IDLE; next line_start completes a full 640-write line.
- eng_done[2] raised while inflight[2]=0 -> eng_ack[2]=0, no wr_en; with DISPATCH_PERF_EN and the 3-cycle engine model -> line_cycles equals the observed cycle count from line_start to line_done.

Source files
------------

// File: rtl/mandel_line_dispatcher_if.sv
// Handshake bundle between the line dispatcher, the engine pool and the results buffer.
// The master side is the dispatcher; the slave side is engines + buffer + line front end.
interface mandel_line_dispatcher_if #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int DEPTH_W     = 10
);
    localparam int ADDR_W = $clog2(X_SIZE);

    logic                           line_start;
    logic                           line_busy;
    logic                           line_done;
    logic [NUM_ENGINES-1:0]         eng_idle;
    logic [NUM_ENGINES-1:0]         eng_start;
    logic [ADDR_W-1:0]              eng_x;
    logic [NUM_ENGINES-1:0]         eng_done;
    logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth;
    logic [NUM_ENGINES-1:0]         eng_ack;
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_addr;
    logic [DEPTH_W-1:0]             wr_data;

    modport master (
        input  line_start, eng_idle, eng_done, eng_depth,
        output line_busy, line_done, eng_start, eng_x, eng_ack, wr_en, wr_addr, wr_data
    );

    modport slave (
        output line_start, eng_idle, eng_done, eng_depth,
        input  line_busy, line_done, eng_start, eng_x, eng_ack, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/mandel_line_dispatcher.sv
// Per-line scheduler: launches pixel indices onto free engines, collects depths round-robin.
// Optional DISPATCH_PERF_EN adds a saturating busy-cycle count per line on line_cycles.
module mandel_line_dispatcher #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int DEPTH_W     = 10
) (
    input  logic                     out_stream_aclk,
    input  logic                     periph_resetn,
    mandel_line_dispatcher_if.master bus
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]              line_cycles
`endif
);
    localparam int ADDR_W = $clog2(X_SIZE);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int PTR_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(X_SIZE - 1);
    localparam logic [CNT_W-1:0] X_TOTAL = CNT_W'(X_SIZE);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_ENGINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [CNT_W-1:0]       next_x_r, written_r;
    logic [NUM_ENGINES-1:0] inflight_r, inflight_nxt_s;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [ADDR_W-1:0]      tag_r [NUM_ENGINES];

    logic [NUM_ENGINES-1:0] eng_start_r, eng_ack_s;
    logic [ADDR_W-1:0]      eng_x_r, wr_addr_r;
    logic [DEPTH_W-1:0]     wr_data_r;
    logic                   wr_en_r, line_done_r, line_busy_r;

    logic                   accept_s, launch_v_s, grant_v_s;
    logic [NUM_ENGINES-1:0] elig_s, req_s, launch_oh_s;
    logic [PTR_W-1:0]       launch_idx_s, grant_idx_s;
    logic [PTR_W:0]         pick_s;

    function automatic logic [NUM_ENGINES-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        return NUM_ENGINES'(1'b1) << idx;
    endfunction

    // Scan downward from the farthest offset so the requester nearest ptr is kept.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                               input logic [PTR_W-1:0]       ptr);
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_ENGINES;
            res = req[idx] ? {1'b1, PTR_W'(idx)} : res;
        end
        return res;
    endfunction

    // Launch selection: lowest free engine that has no result outstanding.
    always_comb begin
        elig_s       = (state_r == ST_DISPATCH) ? (bus.eng_idle & ~inflight_r) : '0;
        launch_v_s   = 1'b0;
        launch_idx_s = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            launch_v_s   = launch_v_s | elig_s[i];
            launch_idx_s = elig_s[i] ? PTR_W'(i) : launch_idx_s;
        end
        launch_oh_s = launch_v_s ? to_onehot(launch_idx_s) : '0;
    end

    // Collect arbitration; done from an engine we never launched is masked out here.
    always_comb begin
        req_s          = ((state_r == ST_DISPATCH) || (state_r == ST_DRAIN)) ?
                         (bus.eng_done & inflight_r) : '0;
        pick_s         = rr_pick(req_s, rr_ptr_r);
        grant_v_s      = pick_s[PTR_W];
        grant_idx_s    = pick_s[PTR_W-1:0];
        eng_ack_s      = grant_v_s ? to_onehot(grant_idx_s) : '0;
        inflight_nxt_s = (inflight_r & ~eng_ack_s) | launch_oh_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.line_start) begin
                    state_nxt_s = ST_DISPATCH;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (launch_v_s && (next_x_r == X_LAST)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                if (written_r == X_TOTAL) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Line bookkeeping, pixel tags and registered outputs.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            next_x_r    <= '0;
            written_r   <= '0;
            inflight_r  <= '0;
            rr_ptr_r    <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                tag_r[i] <= '0;
            end
            eng_start_r <= '0;
            eng_x_r     <= '0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            line_done_r <= 1'b0;
            line_busy_r <= 1'b0;
        end else begin
            if (accept_s) begin
                next_x_r   <= '0;
                written_r  <= '0;
                inflight_r <= '0;
            end else begin
                if (launch_v_s) begin
                    next_x_r <= next_x_r + CNT_W'(1);
                end
                if (grant_v_s) begin
                    written_r <= written_r + CNT_W'(1);
                end
                inflight_r <= inflight_nxt_s;
            end
            if (grant_v_s) begin
                rr_ptr_r <= (grant_idx_s == PTR_MAX) ? '0 : grant_idx_s + PTR_W'(1);
            end
            if (launch_v_s) begin
                tag_r[launch_idx_s] <= next_x_r[ADDR_W-1:0];
            end
            eng_start_r <= launch_oh_s;
            eng_x_r     <= launch_v_s ? next_x_r[ADDR_W-1:0] : '0;
            wr_en_r     <= grant_v_s;
            wr_addr_r   <= grant_v_s ? tag_r[grant_idx_s] : '0;
            wr_data_r   <= grant_v_s ? bus.eng_depth[grant_idx_s*DEPTH_W +: DEPTH_W] : '0;
            line_done_r <= (state_nxt_s == ST_DONE);
            line_busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.eng_start = eng_start_r;
    assign bus.eng_x     = eng_x_r;
    assign bus.eng_ack   = eng_ack_s;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.line_done = line_done_r;
    assign bus.line_busy = line_busy_r;

`ifdef DISPATCH_PERF_EN
    logic [31:0] cyc_cnt_r, line_cycles_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Busy-cycle counter; the DONE cycle itself is included in the latched value.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            cyc_cnt_r     <= 32'd0;
            line_cycles_r <= 32'd0;
        end else begin
            if (accept_s) begin
                cyc_cnt_r <= 32'd0;
            end else if (state_r != ST_IDLE) begin
                cyc_cnt_r <= sat_inc(cyc_cnt_r);
            end
            if (state_r == ST_DONE) begin
                line_cycles_r <= sat_inc(cyc_cnt_r);
            end
        end
    end

    assign line_cycles = line_cycles_r;
`endif
endmodule

// File: tb/tb_mandel_line_dispatcher.sv
// Directed bench for mandel_line_dispatcher with a 4-engine behavioural pool
// (result 3 cycles after start, depth = x % 200) and a write/done monitor.
module tb_mandel_line_dispatcher;
    localparam int NE = 4;
    localparam int XS = 640;
    localparam int DW = 10;
    localparam int AW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mandel_line_dispatcher_if #(.NUM_ENGINES(NE), .X_SIZE(XS), .DEPTH_W(DW)) bus ();
`ifdef DISPATCH_PERF_EN
    logic [31:0] line_cycles;
`endif

    mandel_line_dispatcher #(.NUM_ENGINES(NE), .X_SIZE(XS), .DEPTH_W(DW)) dut (
        .out_stream_aclk (clk),
        .periph_resetn   (rst_n),
        .bus             (bus)
`ifdef DISPATCH_PERF_EN
        ,
        .line_cycles     (line_cycles)
`endif
    );

    // Engine pool model
    logic [NE-1:0] m_busy;
    logic [1:0]    m_cnt [NE];
    logic [AW-1:0] m_x   [NE];
    logic [NE-1:0] hold, idle_mask, force_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= '0;
            for (int i = 0; i < NE; i++) begin
                m_cnt[i] <= 2'd0;
                m_x[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (bus.eng_start[i]) begin
                    m_busy[i] <= 1'b1;
                    m_cnt[i]  <= 2'd2;
                    m_x[i]    <= bus.eng_x;
                end else if (bus.eng_ack[i]) begin
                    m_busy[i] <= 1'b0;
                end else if (m_busy[i] && (m_cnt[i] != 2'd0)) begin
                    m_cnt[i] <= m_cnt[i] - 2'd1;
                end
            end
        end
    end

    assign bus.eng_idle = ~m_busy & idle_mask;

    always_comb begin
        bus.eng_done  = '0;
        bus.eng_depth = '0;
        for (int i = 0; i < NE; i++) begin
            bus.eng_done[i] = (m_busy[i] && (m_cnt[i] == 2'd0) && !hold[i]) || force_done[i];
            bus.eng_depth[i*DW +: DW] = DW'(m_x[i] % AW'(200));
        end
    end

    // Per-line monitor
    int           cyc = 0;
    int           wr_cnt = 0, dup_cnt = 0, data_err = 0, done_cnt = 0;
    int           start0_cnt = 0, ack2_cnt = 0;
    int           last_wr = 0, done_cyc = 0, start_cyc = 0;
    bit [XS-1:0]  seen = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.line_start && !bus.line_busy) begin
                wr_cnt <= 0; dup_cnt <= 0; data_err <= 0; done_cnt <= 0;
                start0_cnt <= 0; ack2_cnt <= 0; seen <= '0; start_cyc <= cyc;
            end else begin
                if (bus.wr_en) begin
                    wr_cnt  <= wr_cnt + 1;
                    last_wr <= cyc;
                    if (int'(bus.wr_addr) >= XS) begin
                        data_err <= data_err + 1;
                    end else begin
                        if (seen[bus.wr_addr]) dup_cnt <= dup_cnt + 1;
                        seen[bus.wr_addr] <= 1'b1;
                        if (bus.wr_data != DW'(bus.wr_addr % AW'(200))) data_err <= data_err + 1;
                    end
                end
                if (bus.line_done) begin
                    done_cnt <= done_cnt + 1;
                    done_cyc <= cyc;
                end
                if (bus.eng_start[0]) start0_cnt <= start0_cnt + 1;
                if (bus.eng_ack[2])   ack2_cnt   <= ack2_cnt + 1;
            end
        end
    end

    int asrt_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        asrt_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.line_start = 1'b1;
        @(negedge clk) bus.line_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000; i++) begin
            if (done_cnt != 0) break;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_line(input string tag);
        check({tag, "/writes"},   wr_cnt,          XS);
        check({tag, "/coverage"}, $countones(seen), XS);
        check({tag, "/dups"},     dup_cnt,         0);
        check({tag, "/data"},     data_err,        0);
        check({tag, "/done_cnt"}, done_cnt,        1);
        check({tag, "/done_lat"}, done_cyc,        last_wr + 1);
        check({tag, "/idle"},     bus.line_busy,   0);
    endtask

    initial begin
        bus.line_start = 1'b0;
        hold       = '0;
        idle_mask  = '1;
        force_done = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst/line_busy", bus.line_busy, 0);
        check("rst/line_done", bus.line_done, 0);
        check("rst/eng_start", bus.eng_start, 0);
        check("rst/eng_x",     bus.eng_x,     0);
        check("rst/eng_ack",   bus.eng_ack,   0);
        check("rst/wr_en",     bus.wr_en,     0);
        check("rst/wr_addr",   bus.wr_addr,   0);
        check("rst/wr_data",   bus.wr_data,   0);

        // Round-robin: hold results until all four engines are done, then release together
        hold = '1;
        pulse_start();
        for (int r = 0; r < 3; r++) begin
            repeat (12) @(negedge clk);
            idle_mask = '0;
            hold = '0;
            #1;
            check("rr/ack0", bus.eng_ack, 4'b0001);
            for (int k = 1; k < 4; k++) begin
                @(negedge clk);
                check("rr/ack",     bus.eng_ack, 32'(4'b0001 << k));
                check("rr/wr_en",   bus.wr_en,   1);
                check("rr/wr_addr", bus.wr_addr, 4 * r + k - 1);
                check("rr/wr_data", bus.wr_data, 4 * r + k - 1);
            end
            @(negedge clk);
            check("rr/ack_none",  bus.eng_ack, 0);
            check("rr/wr_en_l",   bus.wr_en,   1);
            check("rr/wr_addr_l", bus.wr_addr, 4 * r + 3);
            @(negedge clk);
            check("rr/wr_quiet",  bus.wr_en,   0);
            hold = '1;
            idle_mask = '1;
        end
        hold = '0;
        wait_done();
        check_line("lineRR");

        // Normal line with an ignored second line_start mid-line
        pulse_start();
        repeat (50) @(negedge clk);
        check("ignore/busy", bus.line_busy, 1);
        pulse_start();
        wait_done();
        check_line("lineA");
`ifdef DISPATCH_PERF_EN
        check("perf/line_cycles", line_cycles, done_cyc - start_cyc);
`endif

        // Engine 0 never idle
        idle_mask = 4'b1110;
        pulse_start();
        wait_done();
        check_line("lineNoE0");
        check("noe0/start0", start0_cnt, 0);

        // Spurious done on engine 2 that was never launched
        idle_mask  = 4'b1011;
        force_done = 4'b0100;
        pulse_start();
        repeat (20) @(negedge clk);
        check("spur/ack2_now", bus.eng_ack[2], 0);
        wait_done();
        check_line("lineSpur");
        check("spur/ack2_cnt", ack2_cnt, 0);
        force_done = '0;
        idle_mask  = '1;

        // Asynchronous reset after x=100 is launched
        begin
            bit found;
            found = 1'b0;
            pulse_start();
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if ((bus.eng_start != 0) && (bus.eng_x == AW'(100))) begin
                    found = 1'b1;
                    break;
                end
            end
            check("arst/x100_seen", found, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst/line_busy", bus.line_busy, 0);
        check("arst/eng_start", bus.eng_start, 0);
        check("arst/eng_x",     bus.eng_x,     0);
        check("arst/eng_ack",   bus.eng_ack,   0);
        check("arst/wr_en",     bus.wr_en,     0);
        check("arst/wr_addr",   bus.wr_addr,   0);
        check("arst/line_done", bus.line_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst/idle_after", bus.line_busy, 0);
        pulse_start();
        wait_done();
        check_line("lineAfterRst");

        $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
        $finish;
    end
endmodule
